// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and helpers for the I2S transmit sequencer.
// Holds FSM states, frame geometry, the sample-pair container and slot bit lookup.
package i2s_pkg;

   localparam int I2S_SLOT_BITS  = 32;
   localparam int I2S_FRAME_BITS = 64;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN,
      STOP
   } i2s_state_e;

   // Slot-width container; narrower samples sit zero-extended in the low bits.
   typedef struct packed {
      logic [I2S_SLOT_BITS-1:0] left;
      logic [I2S_SLOT_BITS-1:0] right;
   } i2s_pair_t;

   // Serial bit for frame position b: slot bit k=1..w carries sample[w-k].
   function automatic logic i2s_bit(
      input i2s_pair_t   p,
      input logic [5:0]  b,
      input int          w
   );
      logic [4:0]  k;
      logic [31:0] s;
      k = b[4:0];
      s = b[5] ? p.right : p.left;
      if (k == 5'd0 || int'(k) > w) return 1'b0;
      return s[5'(w - int'(k))];
   endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: synchronous FIFO of stereo pairs with combinational read port.
// Ports: clk_i/rst_i, push_i+wdata_i, pop_i, rdata_o (head entry), full_o, empty_o,
// full_nxt_o (full after this cycle's push/pop).
module i2s_tx_fifo #(
   parameter int W     = 48,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o,
   output logic         full_nxt_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr, rd;

   assign full_o     = (cnt_q == CW'(DEPTH));
   assign empty_o    = (cnt_q == '0);
   assign wr         = push_i & ~full_o;
   assign rd         = pop_i & ~empty_o;
   assign cnt_d      = cnt_q + CW'(wr) - CW'(rd);
   assign full_nxt_o = (cnt_d == CW'(DEPTH));
   assign rdata_o    = mem_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (wr) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr) wptr_q <= wptr_q + 1'b1;
         if (rd) rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/i2s_tx_sequencer.sv
// i2s_tx_sequencer: buffers stereo pairs and serialises them as 64-bit I2S frames.
// Ports: ACLK/ARESET, enable, s_tdata/s_tvalid/s_tready stream in, i2s_bclk/i2s_lrclk/
// i2s_sdata out, underrun_cnt, busy, irq/irq_ack (irq live only with I2S_TX_IRQ_EN).
module i2s_tx_sequencer
   import i2s_pkg::*;
#(
   parameter int SAMPLE_W   = 24,
   parameter int BCLK_DIV   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  enable,
   input  logic [2*SAMPLE_W-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic                  i2s_bclk,
   output logic                  i2s_lrclk,
   output logic                  i2s_sdata,
   output logic [15:0]           underrun_cnt,
   output logic                  busy,
   output logic                  irq,
   input  logic                  irq_ack
);

   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   i2s_state_e            state_q, state_d;
   logic [DW-1:0]         div_q, div_d;
   logic [5:0]            bit_q, bit_d;
   logic                  bclk_q, bclk_d;
   logic                  lrclk_q, lrclk_d;
   logic                  sdata_q, sdata_d;
   logic                  rdy_q;
   i2s_pair_t             frame_q, frame_d;
   logic [15:0]           ucnt_q, ucnt_d;
   logic [2*SAMPLE_W-1:0] rdata;
   logic                  push, pop, full, empty, full_nxt;
   logic                  active, div_tc, fall, wrap;
   logic                  stop_end, start, underrun;

   assign push     = s_tvalid & rdy_q & ~full;
   assign active   = (state_q == RUN) || (state_q == STOP);
   assign div_tc   = (div_q == DW'(BCLK_DIV - 1));
   assign fall     = active & div_tc & bclk_q;
   assign wrap     = fall & (bit_q == 6'(I2S_FRAME_BITS - 1));
   // Frame end while stopping leaves without starting (or popping) a new frame.
   assign stop_end = wrap & (state_q == STOP) & ~enable;
   assign start    = wrap & ~stop_end;
   assign pop      = start & ~empty;
   assign underrun = start & empty;

   i2s_tx_fifo #(
      .W     (2*SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (ACLK),
      .rst_i      (ARESET),
      .push_i     (push),
      .wdata_i    (s_tdata),
      .pop_i      (pop),
      .rdata_o    (rdata),
      .full_o     (full),
      .empty_o    (empty),
      .full_nxt_o (full_nxt)
   );

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable) state_d = PRIME;
         PRIME:   if (!enable) state_d = IDLE;
                  else if (!empty) state_d = RUN;
         RUN:     if (!enable) state_d = STOP;
         STOP:    if (enable) state_d = RUN;
                  else if (wrap) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      div_d   = div_q;
      bit_d   = bit_q;
      bclk_d  = bclk_q;
      lrclk_d = lrclk_q;
      sdata_d = sdata_q;
      frame_d = frame_q;
      ucnt_d  = ucnt_q;
      busy    = (state_q != IDLE);
      if (!active) begin
         div_d   = '0;
         bit_d   = 6'd63;
         bclk_d  = 1'b0;
         lrclk_d = 1'b0;
         sdata_d = 1'b0;
      end else begin
         div_d = div_tc ? '0 : div_q + 1'b1;
         if (div_tc) bclk_d = ~bclk_q;
         if (stop_end) begin
            bit_d   = 6'd63;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
         end else if (fall) begin
            bit_d   = bit_q + 6'd1;
            lrclk_d = bit_d[5];
            sdata_d = i2s_bit(frame_q, bit_d, SAMPLE_W);
         end
      end
      // Slot bit 0 is always 0, so the pair loaded here is first needed at bit 1.
      if (start) begin
         if (empty) begin
            frame_d = '0;
         end else begin
            frame_d.left  = 32'(rdata[2*SAMPLE_W-1:SAMPLE_W]);
            frame_d.right = 32'(rdata[SAMPLE_W-1:0]);
         end
      end
      if (underrun && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         div_q   <= '0;
         bit_q   <= 6'd63;
         bclk_q  <= 1'b0;
         lrclk_q <= 1'b0;
         sdata_q <= 1'b0;
         frame_q <= '0;
         ucnt_q  <= '0;
         rdy_q   <= 1'b0;
      end else begin
         div_q   <= div_d;
         bit_q   <= bit_d;
         bclk_q  <= bclk_d;
         lrclk_q <= lrclk_d;
         sdata_q <= sdata_d;
         frame_q <= frame_d;
         ucnt_q  <= ucnt_d;
         rdy_q   <= ~full_nxt;
      end
   end

`ifdef I2S_TX_IRQ_EN
   logic pend_q, pend_d;

   always_comb begin
      pend_d = pend_q;
      if (underrun)     pend_d = 1'b1;
      else if (irq_ack) pend_d = 1'b0;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) pend_q <= 1'b0;
      else        pend_q <= pend_d;
   end

   assign irq = pend_q;
`else
   logic unused_irq_ack;
   assign unused_irq_ack = irq_ack;
   assign irq = 1'b0;
`endif

   assign s_tready     = rdy_q;
   assign i2s_bclk     = bclk_q;
   assign i2s_lrclk    = lrclk_q;
   assign i2s_sdata    = sdata_q;
   assign underrun_cnt = ucnt_q;

endmodule
